instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end:
//   - datapath widths (INSTR_W, ADDR_W) and the sequential PC increment
//   - fetch_state_e : control states of the instruction fetch unit
//   - fetch_entry_t : one fetched instruction with the address it came from
//   - main-decoder opcode constants (instr[31:26]) and a small helper
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  // IDLE : nothing outstanding, may issue when the buffer has room
  // REQ  : a request is outstanding and its data will be kept
  // DROP : a request is outstanding but a redirect made its data stale
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Main decoder opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

  // True for opcodes the main decoder implements.
  function automatic logic opcode_known(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: known = 1'b1;
      default:                                        known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Two-entry buffer of fetched instructions. Entry 0 is always the head, so
// the decoder-facing outputs come straight from a register with no read mux.
//
// Ports:
//   clk, reset    clock and asynchronous active-low reset
//   push          write push_data (never asserted while full)
//   push_data     instruction + fetch address
//   pop           drop the head entry (only while count != 0)
//   flush         empty the buffer; wins over push and pop
//   head          current head entry
//   count         number of valid entries (0..2)
// ----------------------------------------------------------------------------
module fetch_fifo
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;

  assign head = entry0;

  // NOTE: the storage is reset along with the count so instr/instr_pc read
  // as zero during reset; this is cheap at two entries and keeps the
  // decoder inputs deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      // Entries are left as they are; with count at zero nothing reads them.
      count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let entry0 <= entry1 and
      // entry1 <= push_data in the same edge see the pre-edge values.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: keeps the PC, issues at most one instruction-memory
// read at a time, buffers up to two fetched words and hands them to the
// decoder with a valid/ready handshake. A redirect reloads the PC, flushes
// the buffer and discards the data of any request still in flight.
//
// Parameters:
//   RESET_PC     PC loaded while reset is low
//   FIFO_DEPTH   buffer entries; only 2 is supported
//
// Ports:
//   clk, reset               clock and asynchronous active-low reset
//   imem_req/imem_addr       read request and word-aligned address
//   imem_ack/imem_rdata      read response (may arrive in the request cycle)
//   instr_valid/instr/instr_pc   head of the buffer to the decoder
//   instr_ready              decoder accepts the head
//   redirect/redirect_pc     taken branch/jump pulse and its target
//   perf_fetched             instructions delivered (only with FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to add the perf_fetched counter.
// ----------------------------------------------------------------------------
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched
`endif
);

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;   // address held while a request is in flight

  logic         issue_ok;
  logic         ack_fire;
  logic         push;
  logic         pop;
  logic [1:0]   fifo_count;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // A new request only needs registered state (state and buffer count), so
  // there is no combinational path from ack/ready/redirect to imem_req.
  // Issuing straight out of IDLE is what allows back-to-back zero-wait
  // fetches at one per cycle.
  assign issue_ok  = (state == IDLE) && (fifo_count < DEPTH_C);
  assign imem_req  = reset && ((state != IDLE) || issue_ok);
  assign imem_addr = (state == IDLE) ? pc : req_addr;

  assign ack_fire  = imem_req && imem_ack;

  // Data is kept only if the request was not made stale by an earlier
  // redirect (DROP) or by one arriving in this very cycle.
  assign push      = ack_fire && (state != DROP) && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = imem_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          // An ack in the issue cycle completes the request immediately.
          if (issue_ok && !imem_ack) begin
            req_addr <= pc;
            state    <= redirect ? DROP : REQ;
          end
        end
        REQ: begin
          if (imem_ack)      state <= IDLE;
          else if (redirect) state <= DROP;
        end
        DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (redirect)  pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (push) pc <= pc + PC_INC;   // wraps modulo 2^32
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign instr_valid = (fifo_count != 2'd0);
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

`ifdef FETCH_PERF_EN
  // Counts only real deliveries; a pop cancelled by redirect is not one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   perf_fetched <= 32'd0;
    else if (pop) perf_fetched <= perf_fetched + 32'd1;
  end
`endif

endmodule
